gc_conf_loader_fsm: RTL and testbench



---
 rtl/gc_conf_loader_fsm_pkg.sv | 28 ++
 rtl/gc_conf_loader_fsm_if.sv | 26 ++
 rtl/gc_loader_defines.vh | 22 ++
 rtl/mux_conf_ack_select.sv | 26 ++
 rtl/gc_conf_loader_fsm.sv | 121 ++++++++++++
 tb/tb_gc_conf_loader_fsm.sv | 184 ++++++++++++++++++
 6 files changed

// File: rtl/gc_conf_loader_fsm_pkg.sv
// Types and helpers shared by the configuration loader FSM and its interface.
package gc_conf_loader_fsm_pkg;
`include "gc_loader_defines.vh"

    localparam int NUM_COMP = `GC_NUM_COMP;

    typedef enum logic [2:0] {
        ST_IDLE     = `GC_ST_IDLE,
        ST_ISSUE    = `GC_ST_ISSUE,
        ST_WAIT_ACK = `GC_ST_WAIT_ACK,
        ST_DONE     = `GC_ST_DONE,
        ST_ERROR    = `GC_ST_ERROR
    } state_e;

    // Result of a set-bit search over the component mask.
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    function automatic logic [2:0] sel_code(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

    function automatic logic [5:0] onehot(input logic [2:0] idx);
        return 6'd1 << idx;
    endfunction
endpackage

// File: rtl/gc_conf_loader_fsm_if.sv
// Control/status bundle between the Global Controller and the configuration loader.
// start/abort are level requests sampled at each edge; conf_start[i] is a one-cycle
// pulse to component i+1, which answers by raising conf_ack_in[i] in a later cycle.
interface gc_conf_loader_fsm_if;
    logic       start;
    logic       abort;
    logic [5:0] comp_mask;
    logic [5:0] conf_ack_in;
    logic [2:0] sel;
    logic [5:0] conf_start;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] err_comp;
    logic [2:0] dbg_state;

    modport master (
        output start, abort, comp_mask, conf_ack_in,
        input  sel, conf_start, busy, done, error, err_comp, dbg_state
    );

    modport slave (
        input  start, abort, comp_mask, conf_ack_in,
        output sel, conf_start, busy, done, error, err_comp, dbg_state
    );
endinterface

// File: rtl/gc_loader_defines.vh
// Shared encodings for the Global Controller configuration loader:
// FSM state codes, ack-select codes and the number of configurable components.
`ifndef GC_LOADER_DEFINES_VH
`define GC_LOADER_DEFINES_VH

`define GC_ST_IDLE     3'd0
`define GC_ST_ISSUE    3'd1
`define GC_ST_WAIT_ACK 3'd2
`define GC_ST_DONE     3'd3
`define GC_ST_ERROR    3'd4

`define SEL_IDLE       3'd0
`define SEL_CLKGEN     3'd1
`define SEL_INIT       3'd2
`define SEL_STRIDE     3'd3
`define SEL_MINMAX     3'd4
`define SEL_CTRL       3'd5
`define SEL_REINIT     3'd6

`define GC_NUM_COMP    6

`endif

// File: rtl/mux_conf_ack_select.sv
// Selects the acknowledge of the component addressed by the 3-bit ack-select code.
`include "gc_loader_defines.vh"

module mux_conf_ack_select (
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    input  logic [2:0] sel,
    output logic       out
);
    always_comb begin
        out = 1'b0;
        case (sel)
            `SEL_CLKGEN: out = in1;
            `SEL_INIT:   out = in2;
            `SEL_STRIDE: out = in3;
            `SEL_MINMAX: out = in4;
            `SEL_CTRL:   out = in5;
            `SEL_REINIT: out = in6;
            default:     out = 1'b0;
        endcase
    end
endmodule

// File: rtl/gc_conf_loader_fsm.sv
// Walks the latched component mask in ascending order, pulsing each component's
// start and waiting (with an optional timeout) for its selected acknowledge.
`include "gc_loader_defines.vh"

module gc_conf_loader_fsm
    import gc_conf_loader_fsm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMER_WIDTH    = 9
) (
    input logic                 clk,
    input logic                 rst_n,
    gc_conf_loader_fsm_if.slave bus
);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_WIDTH-1:0] TMO_LAST =
        TIMER_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e                 state;
    logic [2:0]             idx;
    logic [5:0]             mask;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   ack_sel;
    pick_t                  first_pick;
    pick_t                  next_pick;

    // Lowest set bit of m at position lo or above.
    function automatic pick_t find_set(input logic [5:0] m, input int lo);
        pick_t p;
        p = '0;
        for (int i = NUM_COMP - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                p.found = 1'b1;
                p.idx   = 3'(i);
            end
        end
        return p;
    endfunction

    assign first_pick    = find_set(bus.comp_mask, 0);
    assign next_pick     = find_set(mask, int'(idx) + 1);
    assign bus.dbg_state = state;

    mux_conf_ack_select u_ack_mux (
        .in1 (bus.conf_ack_in[0]),
        .in2 (bus.conf_ack_in[1]),
        .in3 (bus.conf_ack_in[2]),
        .in4 (bus.conf_ack_in[3]),
        .in5 (bus.conf_ack_in[4]),
        .in6 (bus.conf_ack_in[5]),
        .sel (bus.sel),
        .out (ack_sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.abort) begin
            state          <= ST_IDLE;
            idx            <= '0;
            mask           <= '0;
            timer          <= '0;
            bus.sel        <= `SEL_IDLE;
            bus.conf_start <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.err_comp   <= `SEL_IDLE;
        end else begin
            bus.conf_start <= '0;
            bus.done       <= 1'b0;
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (bus.start) begin
                        bus.error    <= 1'b0;
                        bus.err_comp <= `SEL_IDLE;
                        if (first_pick.found) begin
                            mask           <= bus.comp_mask;
                            idx            <= first_pick.idx;
                            state          <= ST_ISSUE;
                            bus.sel        <= sel_code(first_pick.idx);
                            bus.conf_start <= onehot(first_pick.idx);
                            bus.busy       <= 1'b1;
                        end else begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                // Acks arriving during the start pulse are deliberately not looked at.
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
                    timer <= '0;
                end
                ST_WAIT_ACK: begin
                    if (ack_sel) begin
                        if (next_pick.found) begin
                            idx            <= next_pick.idx;
                            state          <= ST_ISSUE;
                            bus.sel        <= sel_code(next_pick.idx);
                            bus.conf_start <= onehot(next_pick.idx);
                        end else begin
                            state    <= ST_DONE;
                            bus.done <= 1'b1;
                            bus.sel  <= `SEL_IDLE;
                            bus.busy <= 1'b0;
                        end
                    end else if (TMO_EN && timer == TMO_LAST) begin
                        state        <= ST_ERROR;
                        bus.error    <= 1'b1;
                        bus.err_comp <= sel_code(idx);
                        bus.sel      <= `SEL_IDLE;
                        bus.busy     <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gc_conf_loader_fsm.sv
// Bench for the configuration loader: a schedule model predicts every output cycle
// of a sequence from mask, per-component ack delays, abort and reset points.
module tb_gc_conf_loader_fsm;
    localparam int TMO  = 8;
    localparam int MAXC = 128;
    localparam int NEVER = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    gc_conf_loader_fsm_if bus ();

    gc_conf_loader_fsm #(
        .TIMEOUT_CYCLES (TMO),
        .TIMER_WIDTH    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // Sequence description consumed by the model and the driver.
    logic [5:0] seq_mask;
    int         dly [6];
    int         abort_at;
    int         rst_at;
    bit         hold_all;
    bit         noise_en;

    // Output vector layout: sel[14:12] conf_start[11:6] busy[5] done[4] error[3] err_comp[2:0]
    logic [14:0] exp_arr   [MAXC];
    logic [5:0]  ack_arr   [MAXC];
    bit          start_ok  [MAXC];
    int          wait_comp [MAXC];
    int          last_c;
    logic [14:0] exp_q [$];

    function automatic logic [14:0] pack_out(input logic [2:0] s, input logic [5:0] cs,
                                             input logic b, input logic d,
                                             input logic e, input logic [2:0] ec);
        return {s, cs, b, d, e, ec};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic build_model();
        int         t;
        bit         stop;
        bit         err;
        logic [2:0] ec;
        for (int c = 0; c < MAXC; c++) begin
            exp_arr[c]   = '0;
            ack_arr[c]   = '0;
            wait_comp[c] = -1;
            start_ok[c]  = 1'b0;
        end
        t = 1; stop = 1'b0; err = 1'b0; ec = '0;
        for (int i = 0; i < 6; i++) begin
            if (!stop && seq_mask[i]) begin
                exp_arr[t] = pack_out(3'(i + 1), 6'(1 << i), 1'b1, 1'b0, 1'b0, 3'd0);
                if (dly[i] <= TMO) begin
                    for (int j = 1; j <= dly[i]; j++) begin
                        exp_arr[t + j]   = pack_out(3'(i + 1), 6'd0, 1'b1, 1'b0, 1'b0, 3'd0);
                        wait_comp[t + j] = i;
                    end
                    ack_arr[t + dly[i]][i] = 1'b1;
                    t = t + dly[i] + 1;
                end else begin
                    for (int j = 1; j <= TMO; j++) begin
                        exp_arr[t + j]   = pack_out(3'(i + 1), 6'd0, 1'b1, 1'b0, 1'b0, 3'd0);
                        wait_comp[t + j] = i;
                    end
                    t    = t + TMO + 1;
                    err  = 1'b1;
                    ec   = 3'(i + 1);
                    stop = 1'b1;
                end
            end
        end
        if (err) begin
            for (int c = t; c < MAXC; c++) exp_arr[c] = pack_out(3'd0, 6'd0, 1'b0, 1'b0, 1'b1, ec);
        end else begin
            exp_arr[t] = pack_out(3'd0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd0);
        end
        last_c = t + 2;
        if (abort_at > 0 && abort_at <= last_c)
            for (int c = abort_at + 1; c < MAXC; c++) exp_arr[c] = '0;
        if (rst_at > 0 && rst_at <= last_c)
            for (int c = rst_at + 1; c < MAXC; c++) exp_arr[c] = '0;
        for (int c = 1; c <= last_c; c++) begin
            if (hold_all) ack_arr[c] = '1;
            else if (noise_en)
                for (int b = 0; b < 6; b++)
                    if (b != wait_comp[c] && $urandom_range(0, 3) == 0) ack_arr[c][b] = 1'b1;
            start_ok[c] = exp_arr[c][5] | exp_arr[c][4];
        end
    endtask

    task automatic run_seq(input string name);
        logic [14:0] got;
        build_model();
        for (int c = 1; c <= last_c; c++) exp_q.push_back(exp_arr[c]);
        @(posedge clk); #1;
        bus.start       = 1'b1;
        bus.comp_mask   = seq_mask;
        bus.abort       = 1'b0;
        bus.conf_ack_in = '0;
        rst_n           = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            bus.start       = start_ok[c] ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.comp_mask   = 6'($urandom_range(0, 63));
            bus.conf_ack_in = ack_arr[c];
            bus.abort       = (c == abort_at);
            rst_n           = (c != rst_at);
            @(negedge clk);
            got = {bus.sel, bus.conf_start, bus.busy, bus.done, bus.error, bus.err_comp};
            check_eq($sformatf("%s c%0d", name, c), 32'(got), 32'(exp_q.pop_front()));
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.conf_ack_in = '0; rst_n = 1'b1;
    endtask

    task automatic set_seq(input logic [5:0] m, input int d, input int ab, input int rs,
                           input bit hold, input bit noise);
        seq_mask = m;
        for (int i = 0; i < 6; i++) dly[i] = d;
        abort_at = ab; rst_at = rs; hold_all = hold; noise_en = noise;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.comp_mask = '0; bus.conf_ack_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_out", 32'({bus.sel, bus.conf_start, bus.busy, bus.done, bus.error, bus.err_comp}), 32'd0);
        check_eq("reset_state", 32'(bus.dbg_state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_seq(6'b111111, 2, 0, 0, 1'b0, 1'b0);   run_seq("all6_d2");
        set_seq(6'b100101, 1, 0, 0, 1'b0, 1'b0);   run_seq("m100101");
        set_seq(6'b111111, 1, 0, 0, 1'b0, 1'b0);
        dly[2] = NEVER;                             run_seq("tmo_c3");
        set_seq(6'b000001, 1, 0, 0, 1'b0, 1'b0);   run_seq("restart_err");
        set_seq(6'b000011, 1, 0, 0, 1'b1, 1'b0);   run_seq("hold_ack");
        set_seq(6'b000011, 1, 4, 0, 1'b0, 1'b0);   run_seq("abort_c2");
        set_seq(6'b000000, 1, 0, 0, 1'b0, 1'b0);   run_seq("mask0");
        set_seq(6'b111111, 3, 0, 6, 1'b0, 1'b0);   run_seq("rst_mid");
        set_seq(6'b000010, TMO, 0, 0, 1'b0, 1'b1); run_seq("ack_last");
        set_seq(6'b000010, TMO + 1, 0, 0, 1'b0, 1'b1); run_seq("tmo_edge");

        for (int n = 0; n < 40; n++) begin
            seq_mask = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            for (int i = 0; i < 6; i++)
                dly[i] = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(1, TMO));
            abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 20)) : 0;
            rst_at   = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 20)) : 0;
            hold_all = 1'b0;
            noise_en = 1'b1;
            run_seq($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
